// File: rtl/ext_pipe_if.sv
// Valid/ready handshake bundle for the ext_pipe immediate-extension stage.
// master: the decode/operand-mux side; slave: the ext_pipe block itself.
interface ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/ext_pipe.sv
// Pipelined immediate extender: zero/sign/branch-offset/upper forms, with a
// registered output stage plus one skid entry for full-rate valid/ready flow.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    ext_pipe_if.slave  bus
);
    localparam int PAD_W = OUT_W - IN_W;

    logic             main_v_q, main_v_d;
    logic [OUT_W-1:0] main_d_q, main_d_d;
    logic [1:0]       main_m_q, main_m_d;
    logic             skid_v_q, skid_v_d;
    logic [OUT_W-1:0] skid_d_q, skid_d_d;
    logic [1:0]       skid_m_q, skid_m_d;

    logic             in_xfer;
    logic             drain;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] result;

    always_comb begin
        sext = {{PAD_W{bus.in_data[IN_W-1]}}, bus.in_data};
        unique case (bus.in_mode)
            2'b00:   result = {{PAD_W{1'b0}}, bus.in_data};
            2'b01:   result = sext;
            2'b10:   result = {sext[OUT_W-3:0], 2'b00};
            default: result = {bus.in_data, {PAD_W{1'b0}}};
        endcase
    end

    // in_ready comes purely from the skid flag, so no comb path from out_ready.
    assign bus.in_ready  = !skid_v_q;
    assign bus.out_valid = main_v_q;
    assign bus.out_data  = main_d_q;
    assign bus.out_mode  = main_m_q;

    assign in_xfer = bus.in_valid && !skid_v_q;
    assign drain   = main_v_q && bus.out_ready;

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        main_m_d = main_m_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        skid_m_d = skid_m_q;
        if (!main_v_q || drain) begin
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d_d = skid_d_q;
                main_m_d = skid_m_q;
                skid_v_d = 1'b0;
                if (in_xfer) begin
                    skid_v_d = 1'b1;
                    skid_d_d = result;
                    skid_m_d = bus.in_mode;
                end
            end else if (in_xfer) begin
                main_v_d = 1'b1;
                main_d_d = result;
                main_m_d = bus.in_mode;
            end else if (drain) begin
                main_v_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_v_d = 1'b1;
            skid_d_d = result;
            skid_m_d = bus.in_mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q <= 1'b0;
            main_d_q <= '0;
            main_m_q <= '0;
            skid_v_q <= 1'b0;
            skid_d_q <= '0;
            skid_m_q <= '0;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
            main_m_q <= main_m_d;
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
            skid_m_q <= skid_m_d;
        end
    end
endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed vector table, hand-written
// back-pressure/reset sequences and a scoreboarded random stream.
module tb_ext_pipe;
    logic clk;
    logic rst;

    ext_pipe_if #(.IN_W(16), .OUT_W(32)) b16 ();
    ext_pipe_if #(.IN_W(18), .OUT_W(32)) b18 ();

    ext_pipe #(.IN_W(16), .OUT_W(32)) u16 (.clk(clk), .rst(rst), .bus(b16));
    ext_pipe #(.IN_W(18), .OUT_W(32)) u18 (.clk(clk), .rst(rst), .bus(b18));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          wide;
        logic [17:0] data;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] d, input logic [1:0] m);
        logic signed [31:0] s;
        s = 32'(signed'(d));
        case (m)
            2'd0:    return {16'h0000, d};
            2'd1:    return s;
            2'd2:    return s * 4;
            default: return {d, 16'h0000};
        endcase
    endfunction

    initial begin
        vecs[0]  = '{0, 18'h08001, 2'd0, 32'h00008001};
        vecs[1]  = '{0, 18'h08001, 2'd1, 32'hFFFF8001};
        vecs[2]  = '{0, 18'h08001, 2'd2, 32'hFFFE0004};
        vecs[3]  = '{0, 18'h08001, 2'd3, 32'h80010000};
        vecs[4]  = '{0, 18'h01234, 2'd2, 32'h000048D0};
        vecs[5]  = '{0, 18'h0FFFF, 2'd2, 32'hFFFFFFFC};
        vecs[6]  = '{0, 18'h07FFF, 2'd0, 32'h00007FFF};
        vecs[7]  = '{0, 18'h00000, 2'd3, 32'h00000000};
        vecs[8]  = '{1, 18'h20000, 2'd0, 32'h00020000};
        vecs[9]  = '{1, 18'h20000, 2'd1, 32'hFFFE0000};
        vecs[10] = '{1, 18'h20000, 2'd2, 32'hFFF80000};
        vecs[11] = '{1, 18'h20000, 2'd3, 32'h80000000};
        vecs[12] = '{1, 18'h1FFFF, 2'd2, 32'h0007FFFC};
        vecs[13] = '{1, 18'h1FFFF, 2'd3, 32'h7FFFC000};

        rst = 1'b0;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.in_mode = '0; b16.out_ready = 1'b1;
        b18.in_valid = 1'b0; b18.in_data = '0; b18.in_mode = '0; b18.out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("reset out_valid", 32'(b16.out_valid), 32'd0);
        chk("reset in_ready",  32'(b16.in_ready),  32'd1);
        chk("reset out_data",  b16.out_data,       32'h0);
        chk("reset out_mode",  32'(b16.out_mode),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed table: back-to-back, each result one cycle after acceptance
        for (int i = 0; i < 14; i++) begin
            b16.in_valid = !vecs[i].wide;
            b18.in_valid = vecs[i].wide;
            b16.in_data  = vecs[i].data[15:0];
            b18.in_data  = vecs[i].data;
            b16.in_mode  = vecs[i].mode;
            b18.in_mode  = vecs[i].mode;
            step();
            if (vecs[i].wide) begin
                chk($sformatf("vec%0d out_valid", i), 32'(b18.out_valid), 32'd1);
                chk($sformatf("vec%0d out_data", i),  b18.out_data,       vecs[i].exp);
                chk($sformatf("vec%0d out_mode", i),  32'(b18.out_mode),  32'(vecs[i].mode));
            end else begin
                chk($sformatf("vec%0d out_valid", i), 32'(b16.out_valid), 32'd1);
                chk($sformatf("vec%0d out_data", i),  b16.out_data,       vecs[i].exp);
                chk($sformatf("vec%0d out_mode", i),  32'(b16.out_mode),  32'(vecs[i].mode));
            end
        end
        b16.in_valid = 1'b0;
        b18.in_valid = 1'b0;
        step();
        chk("idle u16 out_valid", 32'(b16.out_valid), 32'd0);
        chk("idle u18 out_valid", 32'(b18.out_valid), 32'd0);

        // Back-pressure: main then skid fill, third word held by source
        b16.out_ready = 1'b0;
        b16.in_mode = 2'd1;
        b16.in_valid = 1'b1; b16.in_data = 16'h0001;
        step();
        chk("bp in_ready after 1", 32'(b16.in_ready), 32'd1);
        b16.in_data = 16'h0002;
        step();
        chk("bp in_ready after 2", 32'(b16.in_ready), 32'd0);
        b16.in_data = 16'h0003;
        repeat (3) begin
            step();
            chk("bp in_ready held", 32'(b16.in_ready), 32'd0);
            chk("bp stall data",    b16.out_data,      32'h00000001);
        end
        b16.out_ready = 1'b1;
        chk("bp out0 valid", 32'(b16.out_valid), 32'd1);
        chk("bp out0 data",  b16.out_data,       32'h00000001);
        step();
        chk("bp out1 valid", 32'(b16.out_valid), 32'd1);
        chk("bp out1 data",  b16.out_data,       32'h00000002);
        chk("bp out1 in_ready", 32'(b16.in_ready), 32'd1);
        step();
        b16.in_valid = 1'b0;
        chk("bp out2 valid", 32'(b16.out_valid), 32'd1);
        chk("bp out2 data",  b16.out_data,       32'h00000003);
        step();
        chk("bp drained", 32'(b16.out_valid), 32'd0);

        // Simultaneous drain of main and fill with a new word
        b16.in_valid = 1'b1; b16.in_mode = 2'd0; b16.in_data = 16'hAAAA;
        step();
        b16.in_data = 16'h5555;
        step();
        b16.in_valid = 1'b0;
        chk("drainfill data",     b16.out_data,      32'h00005555);
        chk("drainfill in_ready", 32'(b16.in_ready), 32'd1);
        step();

        // Asynchronous reset with main and skid both occupied
        b16.out_ready = 1'b0;
        b16.in_valid = 1'b1; b16.in_mode = 2'd1; b16.in_data = 16'h1111;
        step();
        b16.in_data = 16'h2222;
        step();
        b16.in_valid = 1'b0;
        chk("pre-reset full in_ready", 32'(b16.in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(b16.out_valid), 32'd0);
        chk("async rst in_ready",  32'(b16.in_ready),  32'd1);
        chk("async rst out_data",  b16.out_data,       32'h0);
        @(negedge clk);
        rst = 1'b0;
        b16.out_ready = 1'b1;
        b16.in_valid = 1'b1; b16.in_mode = 2'd1; b16.in_data = 16'h7FFF;
        step();
        b16.in_valid = 1'b0;
        chk("post-rst valid", 32'(b16.out_valid), 32'd1);
        chk("post-rst data",  b16.out_data,       32'h00007FFF);
        step();
        chk("post-rst empty", 32'(b16.out_valid), 32'd0);

        // Random traffic with in-order scoreboard and stall-stability check
        begin
            logic [31:0] sb[$];
            int          n_in = 0;
            int          n_out = 0;
            int          cyc = 0;
            bit          stall;
            bit          in_x;
            bit          out_x;
            logic [31:0] held_d;
            logic [1:0]  held_m;
            logic [31:0] exp_v;
            while (n_out < 10000 && cyc < 50000) begin
                b16.in_valid  = (n_in < 10000) && ($urandom_range(0, 3) != 0);
                b16.in_data   = 16'($urandom);
                b16.in_mode   = 2'($urandom_range(0, 3));
                b16.out_ready = ($urandom_range(0, 3) != 0);
                in_x   = b16.in_valid && b16.in_ready;
                out_x  = b16.out_valid && b16.out_ready;
                stall  = b16.out_valid && !b16.out_ready;
                held_d = b16.out_data;
                held_m = b16.out_mode;
                if (out_x) begin
                    exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
                    chk("rand out_data", b16.out_data, exp_v);
                    n_out++;
                end
                if (in_x) begin
                    sb.push_back(ref16(b16.in_data, b16.in_mode));
                    n_in++;
                end
                step();
                cyc++;
                if (stall) begin
                    chk("rand stall valid", 32'(b16.out_valid), 32'd1);
                    chk("rand stall data",  b16.out_data,       held_d);
                    chk("rand stall mode",  32'(b16.out_mode),  32'(held_m));
                end
            end
            chk("rand timeout", 32'(n_out), 32'd10000);
            chk("rand accepted", 32'(n_in), 32'd10000);
            chk("rand leftover", 32'(sb.size()), 32'd0);
            b16.in_valid = 1'b0;
            b16.out_ready = 1'b1;
            step();
            chk("rand final empty", 32'(b16.out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit; successor to the fixed-width 18-to-32 sign extender.
- Takes an IN_W-bit immediate plus a mode code; produces an OUT_W-bit operand. Supports zero-extension, sign-extension, branch-offset form (sign-extend then shift left 2) and upper-immediate form (value placed in the top IN_W bits).
- Sits between the decode stage and the operand mux. A one-stage output register plus a one-entry skid buffer give full-throughput valid/ready flow with back-pressure.

Parameters:
- IN_W, 16, width of the immediate input; legal range 2..OUT_W-2.
- OUT_W, 32, width of the extended result; must satisfy OUT_W >= IN_W+2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the in_data/in_mode pair is valid this cycle.
- in_ready  output  1  the block can accept an input this cycle.
- in_data  input  IN_W  immediate field.
- in_mode  input  2  operation select: 00 zero-ext, 01 sign-ext, 10 sign-ext then shl 2, 11 upper.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  the consumer accepts out_data this cycle.
- out_data  output  OUT_W  extended result.
- out_mode  output  2  mode that produced out_data, for downstream tagging.

Behaviour:
- Result function (combinational, computed before registering):
  - 00: {(OUT_W-IN_W) zeros, in_data}.
  - 01: {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
  - 10: mode-01 value shifted left by 2, zero-filled; the top 2 bits of the extended value are discarded.
  - 11: {in_data, (OUT_W-IN_W) zeros}.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready depends only on registered state, never combinationally on out_ready.
- Storage: a main output register (main_v, main_d, main_m) and one skid entry (skid_v, skid_d, skid_m).
- in_ready = !skid_v.
- Latency: an accepted input appears on out_data one cycle later when main is empty or draining. Throughput is one result per cycle while out_ready stays high.
- Per-edge update rules (evaluated in priority order):
  - Main empty, or main draining this cycle:
    - If skid_v: skid moves to main and skid_v clears. If an input also transfers this edge, it loads into skid.
    - Else: an input transfer loads main. With no input, main_v clears when main drains.
  - Main full, not draining, input transfers: input loads into skid and skid_v sets.
  - Main full, not draining, no input: hold.
- Ordering: results leave in strict acceptance order; no drop, no duplication.
- Full condition: main_v && skid_v forces in_ready=0. in_valid is ignored while in_ready=0.
- Held output: while out_valid && !out_ready, out_data and out_mode stay stable.
- Reset: asynchronous.
  - out_valid=0, skid_v=0, out_data=0, out_mode=00, in_ready=1 immediately on assertion.
  - Reset mid-transfer discards both entries.
  - First acceptance is possible on the first rising edge after deassertion.
- X-safety: data registers load only on a transfer, so idle inputs never propagate.

Test Plan:
- IN_W=16, OUT_W=32, out_ready=1. Send 0x8001 in modes 00/01/10/11 on consecutive cycles. Required outputs, one cycle later each: 0x00008001, 0xFFFF8001, 0xFFFE0004, 0x80010000; out_valid high 4 consecutive cycles.
- Back-pressure: hold out_ready=0 and stream 0x0001, 0x0002, 0x0003 in mode 01.
  - Cycle 1 accepted to main; cycle 2 accepted to skid; in_ready=0 from then on.
  - 0x0003 is held by the source.
  - Raise out_ready: outputs 0x00000001, 0x00000002, 0x00000003 in order, with no gaps once 0x0003 is accepted.
- Simultaneous drain and fill: main full, skid empty, out_ready=1 and in_valid=1 in the same cycle. The next cycle shows the new value in main with skid_v=0.
- Reset mid-operation: with both entries full, assert rst asynchronously between edges.
  - out_valid drops to 0 and in_ready rises to 1 before the next edge.
  - After deassertion, a new input 0x7FFF in mode 01 emerges as 0x00007FFF.
- Parameter sweep IN_W=18, OUT_W=32: input 0x20000 mode 01 gives 0xFFFE0000; mode 10 gives 0xFFF80000; mode 11 gives 0x80000000.
- Random traffic: random in_valid/out_ready, 10k transfers, scoreboard compares every output against the reference model in order. Check zero loss, zero duplication, and that out_data is stable while stalled.
